// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: prefetching front end with a latency-1 imem, a small FIFO and epoch-based redirect flush.
module instruction_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 9,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_target_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0]  out_pc_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] pc_q, pc_d, ipc_q;
  logic req_q, req_d, inf_q, iep_q, ep_q, push, pop;
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [INSTR_W-1:0] ins_q [DEPTH];
  logic [ADDR_W-1:0] pcs_q [DEPTH];
  always_comb begin
    pop = (cnt_q != '0) && out_ready_i;
    push = inf_q && (iep_q == ep_q) && !redirect_i;
    cnt_d = redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    // the request issued this cycle becomes in-flight at the edge, so it counts against free slots
    req_d = ({1'b0, cnt_d} + (CW+1)'(req_q)) < (CW+1)'(DEPTH);
    pc_d = redirect_i ? redirect_target_i : pc_q + ADDR_W'(req_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      ipc_q <= '0;
      req_q <= 1'b0;
      inf_q <= 1'b0;
      iep_q <= 1'b0;
      ep_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        pcs_q[i] <= '0;
      end
    end else begin
      pc_q <= pc_d;
      req_q <= req_d;
      cnt_q <= cnt_d;
      inf_q <= req_q;
      ipc_q <= pc_q;
      iep_q <= ep_q;
      ep_q <= ep_q ^ redirect_i;
      rd_q <= redirect_i ? '0 : rd_q + PW'(pop);
      wr_q <= redirect_i ? '0 : wr_q + PW'(push);
      if (push) begin
        ins_q[wr_q] <= imem_rdata_i;
        pcs_q[wr_q] <= ipc_q;
      end
    end
  end
  assign imem_req_o = req_q;
  assign imem_addr_o = req_q ? pc_q : '0;
  assign out_valid_o = cnt_q != '0;
  assign out_instr_o = ins_q[rd_q];
  assign out_pc_o = pcs_q[rd_q];
  assign fifo_count_o = cnt_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of fill, backpressure, redirect, wrap and async reset.
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic rst_n, ready, redirect;
  logic [7:0] tgt;
  logic req, req_w, valid, valid_w;
  logic [7:0] addr, addr_w, pc, pc_w, ep;
  logic [8:0] rdata = '0, rdata_w = '0, instr, instr_w;
  logic [2:0] cnt, cnt_w;
  int checks = 0, errors = 0, nreq;

  always #5 clk = ~clk;

  // instr[i] = i + 9'h100, synchronous read with latency 1
  always @(posedge clk) begin
    rdata <= 9'h100 + {1'b0, addr};
    rdata_w <= 9'h100 + {1'b0, addr_w};
  end

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_target_i(tgt), .out_valid_o(valid), .out_ready_i(ready),
    .out_instr_o(instr), .out_pc_o(pc), .fifo_count_o(cnt)
  );

  instruction_fetch_unit #(.RESET_PC(8'hFE)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_rdata_i(rdata_w),
    .redirect_i(1'b0), .redirect_target_i(8'h00), .out_valid_o(valid_w), .out_ready_i(1'b1),
    .out_instr_o(instr_w), .out_pc_o(pc_w), .fifo_count_o(cnt_w)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " req"}, 16'(req), 16'h0);
    check({tag, " addr"}, 16'(addr), 16'h0);
    check({tag, " valid"}, 16'(valid), 16'h0);
    check({tag, " instr"}, 16'(instr), 16'h0);
    check({tag, " pc"}, 16'(pc), 16'h0);
    check({tag, " cnt"}, 16'(cnt), 16'h0);
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; tgt = 8'h00;
    step();
    step();
    check_zero("rst");
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin
        check("fill req1", 16'(req), 16'h1);
        check("fill addr1", 16'(addr), 16'h0);
        check("wrap addr1", 16'({req_w, addr_w}), 16'h1FE);
      end
      if (k <= 2) check("fill valid", 16'(valid), 16'h0);
      if (k == 2) check("fill addr2", 16'(addr), 16'h1);
      if (k >= 3) begin
        ep = 8'hFE + 8'(k - 3);
        check("seq valid", 16'(valid), 16'h1);
        check("seq pc", 16'(pc), 16'(k - 3));
        check("seq instr", 16'(instr), 16'(9'h100 + 9'(k - 3)));
        check("wrap valid", 16'(valid_w), 16'h1);
        check("wrap pc", 16'(pc_w), 16'(ep));
        check("wrap instr", 16'(instr_w), 16'({1'b1, ep}));
        check("wrap cnt", 16'(cnt_w), 16'h1);
      end
    end
    ready = 1'b0;
    step();
    step();
    check("pre-redir cnt", 16'(cnt), 16'h3);
    check("pre-redir pc", 16'(pc), 16'h5);
    redirect = 1'b1; tgt = 8'h40;
    step();
    redirect = 1'b0; ready = 1'b1;
    check("redir valid N+1", 16'(valid), 16'h0);
    check("redir addr N+1", 16'({req, addr}), 16'h140);
    step();
    check("redir valid N+2", 16'(valid), 16'h0);
    step();
    check("redir valid N+3", 16'(valid), 16'h1);
    check("redir pc N+3", 16'(pc), 16'h40);
    step();
    check("redir pc N+4", 16'(pc), 16'h41);
    check("redir instr N+4", 16'(instr), 16'h141);
    redirect = 1'b1; tgt = 8'h10;
    step();
    tgt = 8'h20;
    check("b2b addr 10", 16'(addr), 16'h10);
    check("b2b valid 1", 16'(valid), 16'h0);
    step();
    redirect = 1'b0;
    check("b2b addr 20", 16'(addr), 16'h20);
    check("b2b valid 2", 16'(valid), 16'h0);
    step();
    check("b2b valid 3", 16'(valid), 16'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("b2b valid", 16'(valid), 16'h1);
      check("b2b pc", 16'(pc), 16'(8'h20 + 8'(k)));
      check("b2b instr", 16'(instr), 16'(9'h120 + 9'(k)));
    end
    ready = 1'b0;
    step();
    step();
    check("mid cnt", 16'(cnt), 16'h3);
    rst_n = 1'b0;
    #1;
    check_zero("async rst");
    step();
    rst_n = 1'b1; ready = 1'b1;
    step();
    check("rst2 addr", 16'({req, addr}), 16'h100);
    step();
    step();
    check("rst2 pc", 16'({valid, pc}), 16'h100);
    check("rst2 instr", 16'(instr), 16'h100);
    rst_n = 1'b0; ready = 1'b0;
    step();
    rst_n = 1'b1; nreq = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (req) nreq++;
    end
    check("bp nreq", 16'(nreq), 16'h4);
    check("bp cnt", 16'(cnt), 16'h4);
    check("bp req", 16'(req), 16'h0);
    ready = 1'b1;
    for (int k = 10; k <= 15; k++) begin
      if (k > 10) step();
      check("bp valid", 16'(valid), 16'h1);
      check("bp pc", 16'(pc), 16'(k - 10));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end stage directly upstream of the core controller.
- Drives instruction-memory addresses and buffers returned 9-bit instructions with their PCs in a small prefetch FIFO.
- Presents them to the controller over a valid/ready handshake.
- Accepts a redirect (taken branch/jump) from the controller, which flushes buffered and in-flight fetches and restarts fetch at the target.

Parameters:
ADDR_W, 8, program-counter / instruction-memory address width
INSTR_W, 9, instruction width
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
imem_req  output  1  fetch request this cycle
imem_addr  output  ADDR_W  fetch address, valid when imem_req=1
imem_rdata  input  INSTR_W  instruction data, valid exactly 1 cycle after a request
redirect  input  1  controller requests fetch restart
redirect_target  input  ADDR_W  restart PC, sampled when redirect=1
out_valid  output  1  FIFO head holds an instruction
out_ready  input  1  controller accepts head this cycle
out_instr  output  INSTR_W  head instruction
out_pc  output  ADDR_W  PC of head instruction
fifo_count  output  clog2(DEPTH+1)  occupied entries, for debug/coverage

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; in-flight flag cleared; epoch=0.
  - All outputs are 0: imem_req, imem_addr, out_valid, out_instr, out_pc, fifo_count.
- Memory timing: synchronous read, latency 1.
  - A request issued in cycle N returns data on imem_rdata in cycle N+1.
  - At most one request is in flight per cycle; back-to-back requests are allowed.
- Request rule (registered): imem_req=1 in a cycle iff fifo_count + inflight < DEPTH, evaluated after that cycle's pop.
  - The FIFO can therefore never overflow; no response is dropped for lack of space.
- imem_addr = fetch_pc. On an issued request, fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_W (8'hFF -> 8'h00).
- Response capture:
  - Each request records its PC and the current epoch bit in an in-flight register.
  - In the following cycle, {imem_rdata, recorded PC} is pushed only if the recorded epoch equals the current epoch; otherwise it is silently discarded.
- Output: out_valid = (fifo_count != 0). out_instr/out_pc come from the FIFO head (registered storage, no combinational path from imem_rdata).
- Transfer: occurs when out_valid & out_ready. The head pops at the clock edge.
  - Push and pop in the same cycle leaves fifo_count unchanged.
- Redirect: redirect=1 at cycle N, sampled at the edge ending N. At that edge:
  - FIFO is cleared (fifo_count=0).
  - epoch toggles.
  - fetch_pc <= redirect_target.
  - Any pending push from a response is dropped.
- Redirect and the handshake in the same cycle:
  - A transfer in cycle N completes normally from the controller's view.
  - The flush overrides the FIFO state.
- Post-redirect timing:
  - Cycle N+1: imem_req=1, imem_addr=redirect_target.
  - Cycle N+2: first valid push.
  - Cycle N+3: out_valid=1 with out_pc=redirect_target.
  - Redirect-to-first-valid latency is 3 cycles.
- Back-to-back redirects: each one restarts from its own target. Only the last target's instructions ever appear.
- Steady state: with out_ready held high, one instruction is delivered per cycle after the 2-cycle fill latency.
- out_ready low: fetch continues until fifo_count + inflight = DEPTH, then imem_req deasserts. Fetch resumes the cycle after a pop frees a slot.
- Reset asserted mid-operation: immediate asynchronous return to reset values; in-flight data is lost. After deassertion, the first request is issued at the first clock edge with imem_addr=RESET_PC.
- fifo_count never exceeds DEPTH. Pop on empty is impossible because transfer requires out_valid.

Test Plan:
- Reset release, out_ready=1, imem holds instr[i]=i+9'h100 -> out_pc sequence 0,1,2,... with out_instr 9'h100,9'h101,...; first out_valid 2 cycles after the first imem_req; one instruction per cycle thereafter.
- out_ready=0 for 10 cycles after reset -> fifo_count saturates at 4, imem_req drops to 0, no requests beyond addr 4; raising out_ready delivers PCs 0..3 then 4 with no gaps or duplicates.
- Redirect to 8'h40 while FIFO holds PCs 5..7 and a fetch of PC 8 is in flight -> PCs 5..8 never appear; next out_pc=8'h40 exactly 3 cycles after the redirect cycle.
- Redirect on consecutive cycles with targets 8'h10 then 8'h20 -> only PCs 8'h20,8'h21,... are delivered.
- RESET_PC=8'hFE, out_ready=1 -> out_pc sequence FE,FF,00,01 (wrap-around).
- Assert reset low mid-stream with fifo_count=3 -> all outputs 0 immediately (asynchronous, before the next edge); after release, delivery restarts at RESET_PC.
